// File: rtl/ps2_command_parser.sv
// ps2_command_parser: parses one "v <n>", "a <n>" or "f" command per 32-char
// ASCII line, scanning one byte per clock. Holds the registered launch
// parameters (velocity, angle) and pulses fire/done/parse_error on commit.
// Optional feature macro: PS2_PARSER_CLAMP_EN (out-of-range values commit as
// the maximum instead of rejecting the line).
module ps2_command_parser #(
    parameter int unsigned VEL_MAX  = 100,
    parameter int unsigned ANG_MAX  = 90,
    parameter int unsigned VEL_INIT = 50,
    parameter int unsigned ANG_INIT = 45
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [255:0] input_line,
    input  logic         line_ready,
    output logic [31:0]  velocity,
    output logic [31:0]  angle,
    output logic         fire,
    output logic         done,
    output logic         parse_error,
    output logic         busy
);

`ifdef PS2_PARSER_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_SP  = 8'h20;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_SP, S_DIG, S_TRAIL, S_COMMIT} state_t;
    typedef enum logic [1:0] {K_NONE, K_VEL, K_ANG, K_FIRE} kind_t;

    state_t        state_q;
    kind_t         kind_q;
    logic [255:0]  line_q;
    logic [4:0]    idx_q;
    logic [31:0]   acc_q;
    logic          ovf_q;
    logic          err_q;
    logic [31:0]   vel_q;
    logic [31:0]   ang_q;
    logic          fire_q;
    logic          done_q;
    logic          perr_q;
    logic          busy_q;

    logic [7:0]    byte_c;
    logic          is_digit_c;
    logic          last_c;
    logic [31:0]   max_c;
    logic [35:0]   sum_c;
    logic [31:0]   acc_d;
    logic          ovf_d;

    // Current byte decode and saturating decimal accumulation
    always_comb begin
        byte_c     = line_q[255:248];
        is_digit_c = (byte_c >= 8'h30) && (byte_c <= 8'h39);
        last_c     = (idx_q == 5'd31);
        max_c      = (kind_q == K_ANG) ? 32'(ANG_MAX) : 32'(VEL_MAX);
        sum_c      = ({4'd0, acc_q} * 36'd10) + {32'd0, byte_c[3:0]};
        if (sum_c > {4'd0, max_c}) begin
            acc_d = max_c;
            ovf_d = 1'b1;
        end else begin
            acc_d = sum_c[31:0];
            ovf_d = ovf_q;
        end
    end

    // Scan FSM, result registers and one-cycle status pulses
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            kind_q  <= K_NONE;
            line_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            vel_q   <= 32'(VEL_INIT);
            ang_q   <= 32'(ANG_INIT);
            fire_q  <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fire_q <= 1'b0;
            done_q <= 1'b0;
            perr_q <= 1'b0;
            if (state_q inside {S_CMD, S_SP, S_DIG, S_TRAIL}) begin
                line_q <= {line_q[247:0], CH_NUL};
                idx_q  <= idx_q + 5'd1;
            end
            case (state_q)
                S_IDLE: begin
                    busy_q <= line_ready;
                    if (line_ready) begin
                        line_q  <= input_line;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        ovf_q   <= 1'b0;
                        err_q   <= 1'b0;
                        kind_q  <= K_NONE;
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    case (byte_c)
                        8'h76, 8'h56: begin kind_q <= K_VEL;  state_q <= S_SP;    end
                        8'h61, 8'h41: begin kind_q <= K_ANG;  state_q <= S_SP;    end
                        8'h66, 8'h46: begin kind_q <= K_FIRE; state_q <= S_TRAIL; end
                        CH_NUL:       begin kind_q <= K_NONE; state_q <= S_COMMIT; end
                        default:      begin err_q  <= 1'b1;   state_q <= S_COMMIT; end
                    endcase
                end
                S_SP: begin
                    if (is_digit_c) begin
                        acc_q   <= acc_d;
                        ovf_q   <= ovf_d;
                        state_q <= last_c ? S_COMMIT : S_DIG;
                    end else if (byte_c == CH_SP && !last_c) begin
                        state_q <= S_SP;
                    end else begin
                        // end of line while still waiting for a value counts as missing
                        err_q   <= 1'b1;
                        state_q <= S_COMMIT;
                    end
                end
                S_DIG: begin
                    if (is_digit_c) begin
                        acc_q   <= acc_d;
                        ovf_q   <= ovf_d;
                        state_q <= last_c ? S_COMMIT : S_DIG;
                    end else if (byte_c == CH_SP) begin
                        state_q <= last_c ? S_COMMIT : S_TRAIL;
                    end else begin
                        err_q   <= (byte_c != CH_NUL);
                        state_q <= S_COMMIT;
                    end
                end
                S_TRAIL: begin
                    if (byte_c == CH_SP) begin
                        state_q <= last_c ? S_COMMIT : S_TRAIL;
                    end else begin
                        err_q   <= (byte_c != CH_NUL);
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= S_IDLE;
                    if (err_q) begin
                        perr_q <= 1'b1;
                    end else begin
                        case (kind_q)
                            K_VEL: begin
                                if (ovf_q && !CLAMP) perr_q <= 1'b1;
                                else                 vel_q  <= acc_q;
                            end
                            K_ANG: begin
                                if (ovf_q && !CLAMP) perr_q <= 1'b1;
                                else                 ang_q  <= acc_q;
                            end
                            K_FIRE:  fire_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign velocity    = vel_q;
    assign angle       = ang_q;
    assign fire        = fire_q;
    assign done        = done_q;
    assign parse_error = perr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ps2_command_parser.sv
// Self-checking bench for ps2_command_parser: directed lines plus random
// command lines, each checked against a tokenising reference parser.
module tb_ps2_command_parser;

`ifdef PS2_PARSER_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic         clock;
    logic         resetn;
    logic [255:0] input_line;
    logic         line_ready;
    logic [31:0]  velocity;
    logic [31:0]  angle;
    logic         fire;
    logic         done;
    logic         parse_error;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int mvel = 50;
    int mang = 45;

    ps2_command_parser #(
        .VEL_MAX (100),
        .ANG_MAX (90),
        .VEL_INIT(50),
        .ANG_INIT(45)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .input_line (input_line),
        .line_ready (line_ready),
        .velocity   (velocity),
        .angle      (angle),
        .fire       (fire),
        .done       (done),
        .parse_error(parse_error),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk(input string s, input bit pad);
        logic [255:0] l;
        l = pad ? {32{8'h20}} : '0;
        for (int i = 0; i < s.len() && i < 32; i++) l[255-8*i -: 8] = s[i];
        return l;
    endfunction

    // Tokenising reference: command letter, optional spaces, number, optional
    // spaces, terminator. endi = byte index where the line is decided.
    function automatic void ref_parse(input logic [255:0] line, output int endi,
                                      output bit err, output int kind, output int val);
        logic [7:0] b [0:32];
        int i;
        for (int j = 0; j < 32; j++) b[j] = line[255-8*j -: 8];
        b[32] = 8'h00;
        err = 0; kind = 0; val = 0; endi = 0;
        case (b[0])
            8'h76, 8'h56: kind = 1;
            8'h61, 8'h41: kind = 2;
            8'h66, 8'h46: kind = 3;
            8'h00: return;
            default: begin err = 1; return; end
        endcase
        i = 1;
        if (kind != 3) begin
            while (b[i] == 8'h20) i++;
            if (!(b[i] >= 8'h30 && b[i] <= 8'h39)) begin
                err = 1; endi = (i > 31) ? 31 : i; return;
            end
            while (b[i] >= 8'h30 && b[i] <= 8'h39) begin
                val = val * 10 + int'(b[i] - 8'h30);
                if (val > 1000) val = 1000;
                i++;
            end
        end
        while (b[i] == 8'h20) i++;
        if (b[i] != 8'h00) err = 1;
        endi = (i > 31) ? 31 : i;
    endfunction

    function automatic logic [255:0] gen_line();
        logic [255:0] l;
        logic [7:0]   cmds [0:9];
        logic [7:0]   c;
        int p;
        int nsp;
        l = '0; p = 0;
        cmds = '{8'h76, 8'h56, 8'h61, 8'h41, 8'h66, 8'h46, 8'h78, 8'h76, 8'h61, 8'h00};
        c = cmds[$urandom_range(0, 9)];
        if (c == 8'h00) return l;
        l[255 -: 8] = c; p = 1;
        nsp = $urandom_range(0, 2);
        for (int k = 0; k < nsp; k++) begin l[255-8*p -: 8] = 8'h20; p++; end
        if (!(c == 8'h66 || c == 8'h46) || $urandom_range(0, 3) == 0) begin
            nsp = $urandom_range(0, 4);
            for (int k = 0; k < nsp; k++) begin
                l[255-8*p -: 8] = 8'(8'h30 + $urandom_range(0, 9)); p++;
            end
        end
        if ($urandom_range(0, 7) == 0) begin l[255-8*p -: 8] = 8'h71; p++; end
        nsp = $urandom_range(0, 3);
        for (int k = 0; k < nsp; k++) begin l[255-8*p -: 8] = 8'h20; p++; end
        if ($urandom_range(0, 5) == 0)
            for (int k = p; k < 32; k++) l[255-8*k -: 8] = 8'h20;
        return l;
    endfunction

    task automatic run_line(input string tag, input logic [255:0] line, input bit intrude);
        int endi, kind, val, got, maxv;
        bit err, exp_perr, exp_fire;
        ref_parse(line, endi, err, kind, val);
        exp_perr = 0; exp_fire = 0;
        if (err) exp_perr = 1;
        else if (kind == 1 || kind == 2) begin
            maxv = (kind == 1) ? 100 : 90;
            if (val > maxv) begin
                if (CLAMP) val = maxv;
                else exp_perr = 1;
            end
            if (!exp_perr) begin
                if (kind == 1) mvel = val;
                else mang = val;
            end
        end else if (kind == 3) exp_fire = 1;

        @(negedge clock);
        input_line = line;
        line_ready = 1'b1;
        @(posedge clock);
        #1;
        line_ready = 1'b0;
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        got = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (intrude) begin
                line_ready = (c == 1);
                input_line = mk("v 99", 1'b0);
            end
            if (done === 1'b1) begin got = c; break; end
        end
        line_ready = 1'b0;
        check({tag, ".latency"}, got, endi + 2);
        check({tag, ".perr"}, {31'd0, parse_error}, {31'd0, exp_perr});
        check({tag, ".fire"}, {31'd0, fire}, {31'd0, exp_fire});
        check({tag, ".vel"}, velocity, mvel);
        check({tag, ".ang"}, angle, mang);
        @(posedge clock);
        #1;
        check({tag, ".after"}, {28'd0, done, fire, parse_error, busy}, 32'd0);
    endtask

    initial begin
        int cnt;
        resetn     = 1'b0;
        line_ready = 1'b0;
        input_line = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst.vel", velocity, 32'd50);
        check("rst.ang", angle, 32'd45);
        check("rst.flags", {28'd0, done, fire, parse_error, busy}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        run_line("v75", mk("v 75", 1'b0), 1'b0);
        check("v75.hex", velocity, 32'h4B);
        run_line("A30", mk("A 30", 1'b0), 1'b0);
        check("A30.ang", angle, 32'd30);
        run_line("f", mk("f", 1'b0), 1'b0);
        run_line("x5", mk("x 5", 1'b0), 1'b0);
        run_line("v_only", mk("v", 1'b0), 1'b0);
        run_line("f2", mk("f 2", 1'b0), 1'b0);
        run_line("v1a", mk("v 1a", 1'b0), 1'b0);
        run_line("v56", mk("v 5 6", 1'b0), 1'b0);
        run_line("a120", mk("a 120", 1'b0), 1'b0);
        check("a120.ang", angle, CLAMP ? 32'd90 : 32'd30);
        run_line("v007", mk("v 007", 1'b0), 1'b0);
        run_line("a0", mk("a 0", 1'b0), 1'b0);
        run_line("v12_intr", mk("v 12", 1'b0), 1'b1);
        check("intr.vel", velocity, 32'd12);
        run_line("empty", '0, 1'b0);
        run_line("full_v9", mk("v 9", 1'b1), 1'b0);
        check("full.vel", velocity, 32'd9);
        run_line("a7", mk("a 7", 1'b0), 1'b0);

        // reset in the middle of a scan
        @(negedge clock);
        input_line = mk("v 77", 1'b0);
        line_ready = 1'b1;
        @(posedge clock);
        #1;
        line_ready = 1'b0;
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        mvel = 50; mang = 45;
        check("midrst.vel", velocity, 32'd50);
        check("midrst.ang", angle, 32'd45);
        check("midrst.busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) cnt++;
        end
        check("midrst.nodone", cnt, 0);

        for (int n = 0; n < 60; n++) run_line("rand", gen_line(), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
